// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: state encoding shared by the serial adder controller and its benches
package serial_add_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational 1-bit full adder used as the serial adder's datapath
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder, LSB first, one full-adder cell reused each cycle.
// Define SERIAL_ADD_SUB_EN to add the sub port (A-B via inverted B and forced carry-in).
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cy, r_busy, r_done, r_co, r_ovf;
  logic             w_s, w_co, w_sub, w_accept;
`ifdef SERIAL_ADD_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif
  assign w_accept = start && (r_state != ST_RUN);
  serial_fa_cell u_cell (
    .a (r_a[0]),
    .b (r_b[0]),
    .ci(r_cy),
    .s (w_s),
    .co(w_co)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_cy    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state <= ST_RUN;
        r_busy  <= 1'b1;
        r_a     <= op_a;
        r_b     <= w_sub ? ~op_b : op_b;
        r_cy    <= w_sub | c_in;
        r_cnt   <= '0;
        r_sum   <= '0;
        r_co    <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (r_state == ST_RUN) begin
        // result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts
        r_cy  <= w_co;
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_sum <= {w_s, r_sum[WIDTH-1:1]};
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          r_co    <= w_co;
          r_ovf   <= r_cy ^ w_co;
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_co;
  assign ovf   = r_ovf;
endmodule
